bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, single-slave bus arbiter.
// Grants are made only from IDLE; contention is resolved round-robin against
// the last contention winner. A BUSY transaction ends on s_ready or, if the
// slave never answers, after TIMEOUT cycles with an error pulse to the owner.
module bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value of the last BUSY cycle allowed before the forced error.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_last_m1;     // 1: m1 won the last contention, so m0 wins the next
    logic        w_last_m1_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_win_m1;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last_m1 <= 1'b1;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last_m1 <= w_last_m1_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state logic plus slave/master outputs for the current state.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_m1_nxt = r_last_m1;
        w_cnt_nxt     = r_cnt;
        w_win_m1      = 1'b0;
        w_timeout     = 1'b0;
        w_done        = 1'b0;
        w_rdata       = 32'd0;
        s_valid       = 1'b0;
        s_addr        = 32'd0;
        s_wdata       = 32'd0;
        s_we          = 1'b0;
        m0_ready      = 1'b0;
        m0_err        = 1'b0;
        m0_rdata      = 32'd0;
        m1_ready      = 1'b0;
        m1_err        = 1'b0;
        m1_rdata      = 32'd0;

        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_win_m1      = !r_last_m1;
                    w_grant_nxt   = w_win_m1 ? 2'b10 : 2'b01;
                    w_last_m1_nxt = w_win_m1;
                    w_state_nxt   = BUSY;
                    w_cnt_nxt     = 8'd0;
                end else if (m0_req) begin
                    w_grant_nxt = 2'b01;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 8'd0;
                end else if (m1_req) begin
                    w_grant_nxt = 2'b10;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 8'd0;
                end
            end
            BUSY: begin
                s_valid   = 1'b1;
                s_addr    = r_grant[1] ? m1_addr  : m0_addr;
                s_wdata   = r_grant[1] ? m1_wdata : m0_wdata;
                s_we      = r_grant[1] ? m1_we    : m0_we;
                // A slave answer in the final cycle still counts as success.
                w_timeout = (r_cnt == LP_CNT_LAST) && !s_ready;
                w_done    = s_ready || w_timeout;
                w_rdata   = s_ready ? s_rdata : 32'd0;
                if (w_done) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                    w_cnt_nxt   = 8'd0;
                    if (r_grant[1]) begin
                        m1_ready = 1'b1;
                        m1_err   = w_timeout;
                        m1_rdata = w_rdata;
                    end else begin
                        m0_ready = 1'b1;
                        m0_err   = w_timeout;
                        m0_rdata = w_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations followed by a randomized phase, all compared every cycle
// against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic        s_valid, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transaction-level reference model ----------------
    // owner: -1 = no transaction, 0/1 = master being served.
    // age: number of BUSY cycles already spent on the current transaction.
    int owner   = -1;
    int age     = 0;
    int last_rr = 1;   // winner of the last contention
    int cyc_no  = 0;

    always @(negedge clk) begin
        logic [135:0] exp_v, act_v;
        logic [1:0]   e_grant;
        logic         e_sv, e_we, e_r0, e_e0, e_r1, e_e1, timed, done;
        logic [31:0]  e_addr, e_wd, e_d0, e_d1, rd;
        if (run) begin
            e_grant = 2'b00; e_sv = 0; e_we = 0; e_addr = 0; e_wd = 0;
            e_r0 = 0; e_e0 = 0; e_d0 = 0; e_r1 = 0; e_e1 = 0; e_d1 = 0;
            timed = 0; done = 0;
            if (reset_n && owner >= 0) begin
                e_grant = (owner == 0) ? 2'b01 : 2'b10;
                e_sv    = 1;
                e_addr  = (owner == 0) ? m0_addr  : m1_addr;
                e_wd    = (owner == 0) ? m0_wdata : m1_wdata;
                e_we    = (owner == 0) ? m0_we    : m1_we;
                timed   = (age == TIMEOUT - 1) && !s_ready;
                done    = s_ready || timed;
                rd      = s_ready ? s_rdata : 32'd0;
                if (owner == 0) begin
                    e_r0 = done; e_e0 = timed; e_d0 = done ? rd : 32'd0;
                end else begin
                    e_r1 = done; e_e1 = timed; e_d1 = done ? rd : 32'd0;
                end
            end
            exp_v = {e_grant, e_sv, e_we, e_addr, e_wd, e_r0, e_e0, e_d0, e_r1, e_e1, e_d1};
            act_v = {grant, s_valid, s_we, s_addr, s_wdata, m0_ready, m0_err, m0_rdata,
                     m1_ready, m1_err, m1_rdata};
            n_chk++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL model cycle=%0d act=%h exp=%h", cyc_no, act_v, exp_v);

            // What the DUT will hold after the coming rising edge.
            if (!reset_n) begin
                owner = -1; age = 0; last_rr = 1;
            end else if (owner < 0) begin
                age = 0;
                if (m0_req && m1_req) begin
                    owner   = (last_rr == 1) ? 0 : 1;
                    last_rr = owner;
                end else if (m0_req) owner = 0;
                else if (m1_req) owner = 1;
            end else if (done) begin
                owner = -1; age = 0;
            end else begin
                age++;
            end
            cyc_no++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endtask

    // Advance to the drive point of the next cycle (just after the rising edge).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        m0_req = 0; m1_req = 0; s_ready = 1;
        repeat (3) cyc();
        s_ready = 0;
    endtask

    task automatic timeout_case(input bit late_ready);
        int early;
        m0_req = 1; m0_we = 0; m0_addr = 32'h300; s_ready = 0; s_rdata = 32'hA5A5A5A5;
        @(negedge clk); chk("to_idle_grant", 32'(grant), 32'h0);
        cyc();
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16 && late_ready) s_ready = 1;
            @(negedge clk);
            if (k < 16) begin
                if (m0_ready || m0_err) early++;
            end else begin
                chk("to_ready16", 32'(m0_ready), 32'h1);
                chk("to_err16", 32'(m0_err), late_ready ? 32'h0 : 32'h1);
                chk("to_rdata16", m0_rdata, late_ready ? 32'hA5A5A5A5 : 32'h0);
                chk("to_svalid16", 32'(s_valid), 32'h1);
            end
            cyc();
        end
        m0_req = 0; s_ready = 0;
        chk("to_no_early_ready", early, 0);
        @(negedge clk);
        chk("to_back_idle", 32'(grant), 32'h0);
        chk("to_m0_ready_after", 32'(m0_ready), 32'h0);
        cyc();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] cexp [8];
        bit stall, seen0, seen1;
        reset_n = 0; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
        run = 1'b1;

        // Reset state
        m0_req = 1; m0_addr = 32'h44;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_svalid", 32'(s_valid), 32'h0);
        chk("rst_m0_ready", 32'(m0_ready), 32'h0);
        cyc();
        m0_req = 0; reset_n = 1;
        cyc();

        // Single read from m0
        m0_req = 1; m0_addr = 32'h100; m0_we = 0; s_ready = 1; s_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("rd_idle_grant", 32'(grant), 32'h0);
        cyc();
        @(negedge clk);
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_saddr", s_addr, 32'h100);
        chk("rd_ready", 32'(m0_ready), 32'h1);
        chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(m0_err), 32'h0);
        cyc();
        m0_req = 0;
        @(negedge clk);
        chk("rd_grant_after", 32'(grant), 32'h0);
        chk("rd_ready_after", 32'(m0_ready), 32'h0);
        settle();

        // Contention held from reset release
        cexp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        reset_n = 0; m0_req = 1; m1_req = 1; s_ready = 1;
        m0_addr = 32'hA0; m1_addr = 32'hB0;
        repeat (2) cyc();
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("cont_grant%0d", i), 32'(grant), 32'(cexp[i]));
            cyc();
        end
        settle();

        // Write from m1
        m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678;
        m0_addr = 32'hFFFF0000; m0_wdata = 32'h0BADF00D; m0_we = 1;
        s_ready = 0; s_rdata = 32'h55AA55AA;
        @(negedge clk); chk("wr_idle_swe", 32'(s_we), 32'h0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) s_ready = 1;
            @(negedge clk);
            chk("wr_swe", 32'(s_we), 32'h1);
            chk("wr_saddr", s_addr, 32'h200);
            chk("wr_swdata", s_wdata, 32'h12345678);
            chk("wr_grant", 32'(grant), 32'h2);
            chk("wr_m0_quiet", {m0_ready, m0_err, 30'd0} | m0_rdata, 32'h0);
            chk("wr_m1_ready", 32'(m1_ready), (k == 2) ? 32'h1 : 32'h0);
            cyc();
        end
        m1_req = 0; m1_we = 0; m0_we = 0;
        settle();

        // Timeout, then slave answering in the final cycle
        timeout_case(1'b0);
        settle();
        timeout_case(1'b1);
        settle();

        // Reset pulsed mid-BUSY after m0 won a contention
        m0_req = 1; m1_req = 1; m0_we = 0; s_ready = 0;
        cyc();
        @(negedge clk); chk("rb_grant_m0", 32'(grant), 32'h1);
        repeat (2) cyc();
        reset_n = 0;
        @(negedge clk);
        chk("rb_grant", 32'(grant), 32'h0);
        chk("rb_svalid", 32'(s_valid), 32'h0);
        chk("rb_saddr", s_addr, 32'h0);
        chk("rb_m0_ready", 32'(m0_ready), 32'h0);
        chk("rb_m0_err", 32'(m0_err), 32'h0);
        cyc();
        @(negedge clk); chk("rb_hold_ready", 32'(m0_ready), 32'h0);
        cyc();
        reset_n = 1;
        @(negedge clk); chk("rb_rel_idle", 32'(grant), 32'h0);
        cyc();
        @(negedge clk); chk("rb_first_m0", 32'(grant), 32'h1);
        settle();

        // m1 drops req in BUSY cycle 2, slave answers in cycle 3
        m1_req = 1; m1_we = 0; m1_addr = 32'h240; s_ready = 0; s_rdata = 32'h01020304;
        cyc();
        cyc();
        m1_req = 0;
        @(negedge clk); chk("drop_no_ready", 32'(m1_ready), 32'h0);
        cyc();
        s_ready = 1;
        @(negedge clk);
        chk("drop_ready", 32'(m1_ready), 32'h1);
        chk("drop_rdata", m1_rdata, 32'h01020304);
        chk("drop_grant", 32'(grant), 32'h2);
        cyc();
        settle();

        // Randomized traffic with stall periods and occasional resets
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) stall = ~stall;
            @(negedge clk);
            seen0 = m0_ready; seen1 = m1_ready;
            @(posedge clk);
            #1;
            reset_n = ($urandom_range(0, 299) != 0);
            if (m0_req && seen0) m0_req = 0;
            else if (!m0_req && $urandom_range(0, 3) == 0) begin
                m0_req = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom_range(0, 1));
            end
            if (m1_req && seen1) m1_req = 0;
            else if (!m1_req && $urandom_range(0, 3) == 0) begin
                m1_req = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom_range(0, 1));
            end
            s_ready = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
        end
        reset_n = 1;
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
